pac_pe: RTL and testbench



---
 rtl/pac_pe.sv | 100 ++++++++++
 tb/tb_pac_pe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pac_pe.sv
// pac_pe: return-path packetizer for a PE. Function-unit results get their
// {type, dst, src, payload} header rebuilt and are queued in a small FIFO.
// The FIFO absorbs NoC back-pressure. Packets go to the router through a
// valid/ready handshake. Results with the reserved type 2'b11 are accepted
// but dropped, and they raise a sticky error flag.
module pac_pe #(
   parameter int         WIDTH   = 32,
   parameter int         INWIDTH = 26,
   parameter logic [2:0] PE_ADDR = 3'd0,
   parameter int         DEPTH   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INWIDTH-1:0] in_data,
   input  logic [2:0]         in_dst,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [15:0]        pkt_cnt,
   output logic               err
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   // Packet storage. Contents are never reset; count decides what is valid.
   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0] wptr_reg;
   logic [AW-1:0] rptr_reg;
   logic [AW:0]   count_reg;
   logic [AW:0]   count_next;
   logic [15:0]   pkt_cnt_reg;
   logic          err_reg;

   logic             hs_in;
   logic             reserved;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] entry;

   // Both handshake outputs come only from registered state. This avoids
   // any combinational path from out_ready or in_valid.
   assign in_ready  = (count_reg != FULL_CNT);
   assign out_valid = (count_reg != '0);
   assign out_data  = mem[rptr_reg];
   assign pkt_cnt   = pkt_cnt_reg;
   assign err       = err_reg;

   assign hs_in    = in_valid && in_ready;
   assign reserved = (in_data[INWIDTH-1 -: 2] == 2'b11);
   assign push     = hs_in && !reserved;
   assign pop      = out_valid && out_ready;

   // Rebuild the header that the depacketizer stripped, and put this PE in the source field.
   assign entry = {in_data[INWIDTH-1 -: 2], in_dst, PE_ADDR, in_data[INWIDTH-3:0]};

   // Write the accepted packet into the slot at the write pointer. No write happens during reset.
   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         mem[wptr_reg] <= entry;
      end
   end

   // Occupancy changes only when exactly one of push and pop happens.
   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   // Update pointers, occupancy, delivered-packet counter and sticky error. Reset takes priority.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_reg    <= '0;
         rptr_reg    <= '0;
         count_reg   <= '0;
         pkt_cnt_reg <= '0;
         err_reg     <= 1'b0;
      end else begin
         count_reg <= count_next;
         if (push) begin
            wptr_reg <= wptr_reg + AW'(1);
         end
         if (pop) begin
            rptr_reg    <= rptr_reg + AW'(1);
            pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
         end
         if (hs_in && reserved) begin
            err_reg <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pac_pe.sv
// tb_pac_pe: self-checking bench for pac_pe. It uses randomized results and
// a queue-based reference model of the FIFO.
module tb_pac_pe;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [25:0] in_data;
   logic [2:0]  in_dst;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [15:0] pkt_cnt;
   logic        err;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: the packets in flight, the delivered count and the sticky error.
   logic [31:0] mq[$];
   int unsigned m_pkt = 0;
   bit          m_err = 0;

   always #5 clk = ~clk;

   pac_pe #(.WIDTH(32), .INWIDTH(26), .PE_ADDR(3'd2), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dst(in_dst),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .pkt_cnt(pkt_cnt), .err(err)
   );

   // Packet layout: type at bit 30, dst at bit 27, src (2) at bit 24, payload below.
   function automatic logic [31:0] make_pkt(logic [25:0] d, logic [2:0] dst);
      logic [1:0]  t;
      logic [23:0] p;
      t = d[25:24];
      p = d[23:0];
      return 32'(t) * 32'h4000_0000 + 32'(dst) * 32'h0800_0000 + 32'd2 * 32'h0100_0000 + 32'(p);
   endfunction

   // Random non-reserved result.
   task automatic rand_input();
      in_data = {2'($urandom_range(0, 2)), 24'($urandom)};
      in_dst  = 3'($urandom);
   endtask

   // Advance one clock. The model applies the same accept/deliver rules to the driven inputs.
   task automatic tick();
      bit acc;
      bit pop;
      if (!rst_n) begin
         mq.delete();
         m_pkt = 0;
         m_err = 0;
      end else begin
         acc = in_valid && (mq.size() < DEPTH);
         pop = out_ready && (mq.size() != 0);
         if (pop) begin
            void'(mq.pop_front());
            m_pkt = (m_pkt + 1) % 65536;
         end
         if (acc) begin
            if (in_data[25:24] == 2'b11) m_err = 1;
            else mq.push_back(make_pkt(in_data, in_dst));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_dst = '0;
      tick(); tick();
      rst_n = 1'b1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      n_tests++; if (pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_pkt_cnt got=%0d exp=0", pkt_cnt); end
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
      $display("[TB] reset done");
   endtask

   task automatic test_single();
      in_data = 26'h1ABCDEF; in_dst = 3'd5; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
      n_tests++; if (out_data !== 32'h6AABCDEF) begin n_fail++; $display("FAIL single_out_data got=%h exp=6aabcdef", out_data); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_tests++; if (pkt_cnt !== 16'd1) begin n_fail++; $display("FAIL single_pkt_cnt got=%0d exp=1", pkt_cnt); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty got=%b exp=0", out_valid); end
      $display("[TB] single packet 6aabcdef pkt_cnt=%0d", pkt_cnt);
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         rand_input();
         in_data[23:0] = 24'(i);
         in_valid = 1'b1;
         tick();
         n_tests++;
         if (in_ready !== (i < 4)) begin
            n_fail++; $display("FAIL bp_in_ready_%0d got=%b exp=%b", i, in_ready, (i < 4));
         end
      end
      in_data[23:0] = 24'd5;
      tick();
      in_valid = 1'b0;
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_fifth_in_ready got=%b exp=0", in_ready); end
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         n_tests++;
         if (out_valid !== 1'b1 || out_data[23:0] !== 24'(i) || out_data !== mq[0]) begin
            n_fail++; $display("FAIL bp_order_%0d got=%h exp=%h", i, out_data, mq[0]);
         end
         tick();
         if (i == 1) begin
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop got=%b exp=1", in_ready); end
         end
      end
      out_ready = 1'b0;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
      $display("[TB] backpressure 4 accepted, 5th refused, drained in order");
   endtask

   task automatic test_streaming();
      logic [15:0] start;
      start = 16'(m_pkt);
      in_valid = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         rand_input();
         n_tests++;
         if (out_valid !== (mq.size() != 0) || (mq.size() != 0 && out_data !== mq[0]) || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL stream_cycle_%0d got v=%b d=%h r=%b exp v=%b", c, out_valid, out_data, in_ready, (mq.size() != 0));
         end
         tick();
      end
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      n_tests++;
      if (pkt_cnt !== start + 16'd20 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL stream_pkt_cnt got=%0d exp=%0d", pkt_cnt, start + 16'd20);
      end
      $display("[TB] streaming 20 cycles pkt_cnt=%0d", pkt_cnt);
   endtask

   task automatic test_wrap();
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin rand_input(); tick(); end
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         rand_input();
         n_tests++;
         if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== mq[0]) begin
            n_fail++; $display("FAIL wrap_cycle_%0d got v=%b r=%b d=%h exp d=%h", c, out_valid, in_ready, out_data, mq[0]);
         end
         tick();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (out_valid !== 1'b1 || out_data !== mq[0]) begin
            n_fail++; $display("FAIL wrap_drain_%0d got v=%b d=%h exp d=%h", i, out_valid, out_data, mq[0]);
         end
         tick();
      end
      out_ready = 1'b0;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_empty got=%b exp=0", out_valid); end
      $display("[TB] push+pop at count 3 for 8 cycles, order kept");
   endtask

   task automatic test_reserved();
      in_data = {2'b11, 24'h123456}; in_dst = 3'd1; in_valid = 1'b1; out_ready = 1'b0;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rsv_in_ready got=%b exp=1", in_ready); end
      tick();
      in_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rsv_out_valid got=%b exp=0", out_valid); end
      n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL rsv_err got=%b exp=1", err); end
      in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin rand_input(); tick(); end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         n_tests++;
         if (out_data !== mq[0]) begin n_fail++; $display("FAIL rsv_traffic_%0d got=%h exp=%h", i, out_data, mq[0]); end
         tick();
      end
      out_ready = 1'b0;
      n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL rsv_err_sticky got=%b exp=1", err); end
      $display("[TB] reserved type dropped, err=%b", err);
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin rand_input(); tick(); end
      rst_n = 1'b0; out_ready = 1'b1;
      rand_input();
      tick();
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || pkt_cnt !== 16'd0 || err !== 1'b0) begin
         n_fail++; $display("FAIL midreset got v=%b r=%b cnt=%0d err=%b exp v=0 r=1 cnt=0 err=0", out_valid, in_ready, pkt_cnt, err);
      end
      $display("[TB] mid-operation reset cleared state");
   endtask

   task automatic test_counter_wrap();
      int pops = 0;
      int cyc = 0;
      in_valid = 1'b1; out_ready = 1'b1;
      while (pops < 65536 && cyc < 70000) begin
         rand_input();
         if (mq.size() != 0) begin
            if (out_data !== mq[0]) begin
               n_tests++; n_fail++;
               $display("FAIL cwrap_data pop=%0d got=%h exp=%h", pops, out_data, mq[0]);
            end
            pops++;
         end
         tick();
         cyc++;
         if (pops == 65535 && mq.size() != 0) begin
            n_tests++;
            if (pkt_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL cwrap_max got=%h exp=ffff", pkt_cnt); end
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      n_tests++;
      if (pops < 65536) begin n_fail++; $display("FAIL cwrap_timeout got=%0d pops exp=65536", pops); end
      n_tests++;
      if (pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL cwrap_zero got=%0d exp=0", pkt_cnt); end
      $display("[TB] delivered %0d packets, pkt_cnt=%0d", pops, pkt_cnt);
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_streaming();
      test_wrap();
      test_reserved();
      test_reset_mid();
      test_counter_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
